seg7_scan_encoder: RTL and testbench
====================================

# seg7_scan_encoder

Captures active-low seven-segment patterns from a time-multiplexed display scan bus and converts them back into hex nibbles. It is the inverse of the segment decoder and serves as the display loopback/self-check path on the FPGA board. It debounces each digit and assembles a full frame of NUM_DIGITS nibbles into one word. The word goes to the MIPS memory-mapped I/O logic over a valid/ready handshake.

## Interface
- NUM_DIGITS, 8: digits per frame; range 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required to commit a digit; range 1..255.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- scan_en  in  1  sample strobe; digit_sel/seg_in are sampled only when 1.
- digit_sel  in  NUM_DIGITS  one-hot, active-high digit select.
- seg_in  in  7  active-low segments; bit 0 = a … bit 6 = g.
- out_valid  out  1  frame word available.
- out_ready  in  1  consumer accepts the word.
- out_word  out  4*NUM_DIGITS  digit i occupies bits 4i+3:4i.
- out_err  out  NUM_DIGITS  bit i = digit i pattern was not a legal hex glyph.

## Operation
- Encode table, seg_in (g..a) -> nibble:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Any other pattern, including blank 1111111, encodes to nibble 0 with err = 1.
- Debounce FSM. Registers: prev_sel, prev_seg, cnt (8 bit). States:
  - IDLE: no sample tracked.
  - TRACK: counting matches.
  - LOCKED: committed, waiting for a change.
- Transitions, evaluated only when scan_en = 1:
  - digit_sel not one-hot (zero or multi-bit): go to IDLE, cnt <= 0. The sample is ignored.
  - Valid sample differing from prev (or any valid sample in IDLE): prev <= sample, cnt <= 1, go to TRACK. If STABLE_CYCLES = 1, commit immediately and go to LOCKED.
  - TRACK, matching sample: cnt <= cnt+1. When cnt+1 == STABLE_CYCLES, commit and go to LOCKED.
  - LOCKED, matching sample: no change, no re-commit.
- scan_en = 0: all debounce state holds.
- Commit for digit i: slot[i] <= encoded nibble, errslot[i] <= err flag, seen[i] <= 1. Re-committing an already-seen digit overwrites the slot.
- Frame transfer happens when seen is all ones and (!out_valid || out_ready):
  - out_word <= slot, out_err <= errslot, out_valid <= 1, seen <= 0.
  - If a commit lands in the same cycle, it writes its slot and sets its bit in the freshly cleared seen.
- Handshake:
  - out_word/out_err hold stable while out_valid && !out_ready.
  - out_valid falls after out_valid && out_ready unless a new transfer occurs in that same cycle.
- Frame complete while the output is held: slots keep being overwritten by newer commits. The most recent values transfer once the output frees.

## Timing
- Reset values: out_valid = 0, out_word = 0, out_err = 0, seen = 0, slots = 0, cnt = 0, state IDLE. Reset overrides all other activity, including mid-frame and mid-handshake; a partial frame is discarded.
- Commit latency: first sample registered at edge k. With STABLE_CYCLES matching samples at edges k..k+S-1, the slot updates at edge k+S-1.
- Transfer latency: out_valid rises at the edge after the commit that completes seen.
- Throughput: one frame word per cycle at most; no bubble is required between back-to-back transfers when out_ready = 1.

## Test plan
- Reset: assert rst for 2 cycles mid-activity -> out_valid = 0, out_word = 0x00000000, out_err = 0x00.
- Clean frame: digits 0..7 show glyphs 1,2,3,4,5,6,7,8, each held 4 samples, out_ready = 1 -> out_valid pulses once, one cycle after the last commit; out_word = 0x87654321, out_err = 0x00.
- Glitch rejection: digit 3 shows 0110000 for 3 samples, then 0100100 for 4 samples -> slot 3 = 2. Only one commit occurs, at the 4th sample of the second pattern.
- Illegal pattern: digit 5 held at 1111111, remaining digits show F -> out_word = 0xFF0FFFFF, out_err = 0x20.
- Backpressure: out_ready = 0 while a second frame of all-A completes after frame 0x87654321 -> out_word holds 0x87654321. After one cycle of out_ready = 1, the next cycle shows out_word = 0xAAAAAAAA with out_valid = 1.
- Bad select / scan_en gaps:
  - digit_sel = 0x03 between two matching samples -> counter restarts and no commit until 4 fresh matches.
  - scan_en = 0 gaps inside a run -> the count is preserved and the commit still occurs on the 4th enabled match.

Source files
------------

// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder: debounces a multiplexed active-low 7-seg scan bus back into a frame of hex nibbles
//   clk/rst            : clock, synchronous active-high reset
//   scan_en            : sample strobe for digit_sel/seg_in
//   digit_sel, seg_in  : one-hot digit select, active-low segments (bit0=a .. bit6=g)
//   out_valid/out_ready: valid/ready handshake for the assembled frame
//   out_word, out_err  : nibble i at [4i+3:4i], err bit i flags an illegal glyph on digit i
module seg7_scan_encoder #(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_en,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic [6:0]              seg_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_word,
  output logic [NUM_DIGITS-1:0]   out_err
);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  state_t r_state, w_state_nxt;
  logic [NUM_DIGITS-1:0] r_prev_sel, r_seen, r_errslot, r_err;
  logic [6:0] r_prev_seg;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] r_slot, r_word;
  logic r_valid, w_load, w_commit, w_onehot, w_match, w_err, w_xfer;
  logic [3:0] w_nib;
  logic [2:0] w_idx;
  assign w_onehot = $countones(digit_sel) == 1;
  assign w_match = digit_sel == r_prev_sel && seg_in == r_prev_seg;
  assign w_xfer = &r_seen && (!r_valid || out_ready);
  assign out_valid = r_valid;
  assign out_word = r_word;
  assign out_err = r_err;
  always_comb begin
    w_nib = '0;
    w_err = 1'b1;
    w_idx = '0;
    for (int i = 0; i < 16; i++)
      if (seg_in == GLYPH[i]) begin
        w_nib = 4'(i);
        w_err = 1'b0;
      end
    for (int i = 0; i < NUM_DIGITS; i++)
      if (digit_sel[i]) w_idx = 3'(i);
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_load = 1'b0;
    w_commit = 1'b0;
    if (scan_en) begin
      if (!w_onehot) begin
        w_state_nxt = IDLE;
        w_cnt_nxt = '0;
      end else if (r_state == IDLE || !w_match) begin
        w_load = 1'b1;
        w_cnt_nxt = 8'd1;
        w_commit = STABLE_CYCLES == 1;
        w_state_nxt = w_commit ? LOCKED : TRACK;
      end else if (r_state == TRACK) begin
        w_cnt_nxt = r_cnt + 8'd1;
        w_commit = w_cnt_nxt == 8'(STABLE_CYCLES);
        w_state_nxt = w_commit ? LOCKED : TRACK;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_prev_sel <= '0;
      r_prev_seg <= '0;
      r_slot <= '0;
      r_errslot <= '0;
      r_seen <= '0;
      r_valid <= 1'b0;
      r_word <= '0;
      r_err <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_load) begin
        r_prev_sel <= digit_sel;
        r_prev_seg <= seg_in;
      end
      // transfer captures pre-commit slots; a same-cycle commit lands in the next frame
      if (w_xfer) begin
        r_word <= r_slot;
        r_err <= r_errslot;
        r_valid <= 1'b1;
      end else if (out_ready) r_valid <= 1'b0;
      if (w_commit) begin
        r_slot[4*w_idx +: 4] <= w_nib;
        r_errslot[w_idx] <= w_err;
      end
      // digit_sel is one-hot whenever a commit happens
      r_seen <= (w_xfer ? '0 : r_seen) | (w_commit ? digit_sel : '0);
    end
  end
endmodule

// File: tb/tb_seg7_scan_encoder.sv
// tb_seg7_scan_encoder: directed and random scan stimulus checked against a run-length reference model
module tb_seg7_scan_encoder;
  localparam int S = 4;
  logic clk = 0, rst, scan_en, out_ready, out_valid;
  logic [7:0] digit_sel, out_err;
  logic [6:0] seg_in;
  logic [31:0] out_word;
  int n_cmp = 0, n_bad = 0;
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [7:0] m_sel;
  logic [6:0] m_seg;
  bit m_have, m_valid;
  int m_run;
  logic [3:0] m_slot [8];
  logic [7:0] m_eslot, m_seen, m_err;
  logic [31:0] m_word;

  always #5 clk = ~clk;

  seg7_scan_encoder #(.NUM_DIGITS(8), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .digit_sel(digit_sel), .seg_in(seg_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_err(out_err));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: a digit commits on exactly the S-th consecutive identical enabled one-hot sample
  task automatic model_update();
    bit xfer, commit;
    int idx;
    logic [3:0] nib;
    bit err;
    xfer = m_seen == 8'hFF && (!m_valid || out_ready);
    commit = 0;
    idx = 0;
    nib = 0;
    err = 1;
    for (int g = 0; g < 16; g++)
      if (seg_in == glyph[g]) begin
        nib = 4'(g);
        err = 0;
      end
    for (int i = 0; i < 8; i++)
      if (digit_sel[i]) idx = i;
    if (scan_en) begin
      if ($countones(digit_sel) != 1) begin
        m_have = 0;
        m_run = 0;
      end else begin
        if (m_have && digit_sel == m_sel && seg_in == m_seg) m_run++;
        else begin
          m_have = 1;
          m_sel = digit_sel;
          m_seg = seg_in;
          m_run = 1;
        end
        commit = m_run == S;
      end
    end
    if (rst) begin
      m_have = 0;
      m_run = 0;
      for (int i = 0; i < 8; i++) m_slot[i] = 0;
      m_eslot = 0;
      m_seen = 0;
      m_valid = 0;
      m_word = 0;
      m_err = 0;
    end else begin
      if (xfer) begin
        for (int i = 0; i < 8; i++) m_word[4*i +: 4] = m_slot[i];
        m_err = m_eslot;
        m_valid = 1;
        m_seen = 0;
      end else if (out_ready) m_valid = 0;
      if (commit) begin
        m_slot[idx] = nib;
        m_eslot[idx] = err;
        m_seen[idx] = 1;
      end
    end
  endtask

  task automatic step(logic r, logic en, logic [7:0] sel, logic [6:0] seg);
    rst = r;
    scan_en = en;
    digit_sel = sel;
    seg_in = seg;
    @(posedge clk);
    model_update();
    #1;
    check("valid", 32'(out_valid), 32'(m_valid));
    check("word", out_word, m_word);
    check("err", 32'(out_err), 32'(m_err));
  endtask

  task automatic show(int d, logic [6:0] seg, int n);
    for (int k = 0; k < n; k++) step(0, 1, 8'(1 << d), seg);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 7'h7F);
  endtask

  initial begin
    out_ready = 1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_word", out_word, 0);
    check("reset_err", 32'(out_err), 0);
    for (int d = 0; d < 8; d++) show(d, glyph[d+1], 4);
    idle();
    check("clean_valid", 32'(out_valid), 1);
    check("clean_word", out_word, 32'h87654321);
    check("clean_err", 32'(out_err), 0);
    idle();
    check("clean_pulse", 32'(out_valid), 0);
    for (int d = 0; d < 8; d++) if (d != 3) show(d, glyph[15], 4);
    show(3, glyph[3], 3);
    show(3, glyph[2], 3);
    check("glitch_early", 32'(out_valid), 0);
    show(3, glyph[2], 1);
    idle();
    check("glitch_word", out_word, 32'hFFFF2FFF);
    for (int d = 0; d < 8; d++) show(d, d == 5 ? 7'h7F : glyph[15], 4);
    idle();
    check("illegal_word", out_word, 32'hFF0FFFFF);
    check("illegal_err", 32'(out_err), 32'h20);
    step(1, 1, 8'h01, glyph[1]);
    step(1, 0, 0, 0);
    out_ready = 0;
    for (int d = 0; d < 8; d++) show(d, glyph[d+1], 4);
    idle();
    for (int d = 0; d < 8; d++) show(d, glyph[10], 4);
    idle();
    check("bp_hold_word", out_word, 32'h87654321);
    check("bp_hold_valid", 32'(out_valid), 1);
    out_ready = 1;
    idle();
    out_ready = 0;
    check("bp_next_word", out_word, 32'hAAAAAAAA);
    idle();
    check("bp_next_valid", 32'(out_valid), 1);
    out_ready = 1;
    idle();
    for (int d = 1; d < 8; d++) show(d, glyph[d], 4);
    show(0, glyph[1], 2);
    step(0, 1, 8'h03, glyph[1]);
    show(0, glyph[1], 3);
    idle();
    check("badsel_none", 32'(out_valid), 0);
    show(0, glyph[1], 1);
    idle();
    check("badsel_word", out_word, 32'h76543211);
    for (int d = 1; d < 8; d++) show(d, glyph[9], 4);
    show(0, glyph[12], 1);
    step(0, 0, 8'h55, 7'h00);
    show(0, glyph[12], 1);
    step(0, 0, 8'h01, 7'h12);
    step(0, 0, 8'h00, glyph[3]);
    show(0, glyph[12], 1);
    idle();
    check("gap_none", 32'(out_valid), 0);
    show(0, glyph[12], 1);
    idle();
    check("gap_word", out_word, 32'h9999999C);
    for (int r = 0; r < 400; r++) begin
      int d, n, g;
      logic [6:0] seg;
      d = $urandom_range(0, 7);
      g = $urandom_range(0, 19);
      seg = g < 16 ? glyph[g] : 7'($urandom);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        out_ready = $urandom_range(0, 9) < 7;
        if ($urandom_range(0, 4) == 0) step(0, 0, 8'($urandom), 7'($urandom));
        if ($urandom_range(0, 29) == 0) step(0, 1, 8'($urandom), seg);
        if ($urandom_range(0, 199) == 0) step(1, $urandom_range(0, 1) == 1, 8'(1 << d), seg);
        step(0, 1, 8'(1 << d), seg);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
